// File: rtl/dmem_arb_pkg.sv
// Shared encodings and helpers for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_e;
  typedef enum logic {ARB = 1'b0, B_LOCKED = 1'b1} state_e;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles port B was refused; limit_hit forces a B grant.
module dmem_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign limit_hit = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter (CPU = A, debug/loader = B) in front of a single-port synchronous data memory.
// Optional B bus lock is built with DMEM_ARB_LOCK_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              a_req_valid,
  output logic                              a_req_ready,
  input  logic                              a_req_we,
  input  logic [ADDR_WIDTH-1:0]             a_req_addr,
  input  logic [be_width(DATA_WIDTH)-1:0]   a_req_be,
  input  logic [DATA_WIDTH-1:0]             a_req_wdata,
  output logic                              a_rsp_valid,
  output logic [DATA_WIDTH-1:0]             a_rsp_rdata,
  input  logic                              b_req_valid,
  output logic                              b_req_ready,
  input  logic                              b_req_we,
  input  logic [ADDR_WIDTH-1:0]             b_req_addr,
  input  logic [be_width(DATA_WIDTH)-1:0]   b_req_be,
  input  logic [DATA_WIDTH-1:0]             b_req_wdata,
  output logic                              b_rsp_valid,
  output logic [DATA_WIDTH-1:0]             b_rsp_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                              b_lock,
`endif
  output logic                              mem_en,
  output logic [be_width(DATA_WIDTH)-1:0]   mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int unsigned BE_W = be_width(DATA_WIDTH);

  state_e state_q;
  owner_e rsp_owner_q;
  logic   rsp_pend_q;
  logic   a_gnt;
  logic   b_gnt;
  logic   limit_hit;
  logic   starve_inc;

  // Grant: A has priority unless B hit the starvation limit; lock gives B the bus exclusively.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == B_LOCKED) begin
        b_gnt = b_req_valid;
      end else if (a_req_valid && b_req_valid) begin
        b_gnt = limit_hit;
        a_gnt = !limit_hit;
      end else begin
        a_gnt = a_req_valid;
        b_gnt = b_req_valid;
      end
    end
  end

  assign a_req_ready = a_gnt;
  assign b_req_ready = b_gnt;

  always_comb begin
    mem_en    = a_gnt | b_gnt;
    mem_we    = '0;
    mem_addr  = a_req_addr;
    mem_wdata = a_req_wdata;
    if (b_gnt) begin
      mem_addr  = b_req_addr;
      mem_wdata = b_req_wdata;
      mem_we    = b_req_we ? b_req_be : BE_W'(0);
    end else if (a_gnt) begin
      mem_we    = a_req_we ? a_req_be : BE_W'(0);
    end
  end

  assign starve_inc = b_req_valid && !b_gnt && (state_q == ARB);

  dmem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!starve_inc),
    .inc       (starve_inc),
    .limit_hit (limit_hit)
  );

  // Read data arrives one cycle after the access; the tag remembers who issued it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWNER_A;
    end else begin
      rsp_pend_q  <= (a_gnt && !a_req_we) || (b_gnt && !b_req_we);
      rsp_owner_q <= b_gnt ? OWNER_B : OWNER_A;
    end
  end

  assign a_rsp_valid = rsp_pend_q && (rsp_owner_q == OWNER_A);
  assign b_rsp_valid = rsp_pend_q && (rsp_owner_q == OWNER_B);
  assign a_rsp_rdata = mem_rdata;
  assign b_rsp_rdata = mem_rdata;

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
    end else begin
      case (state_q)
        ARB:      if (b_gnt && b_lock) state_q <= B_LOCKED;
        B_LOCKED: if (!b_lock) state_q <= ARB;
        default:  state_q <= ARB;
      endcase
    end
  end
`else
  assign state_q = ARB;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed plus randomized bench for dmem_port_arbiter with a behavioural memory and reference model.
module tb_dmem_port_arbiter;

  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int          LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [BW-1:0] a_req_be;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [BW-1:0] b_req_be;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          b_lock;
`endif
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] sram_w;

  // Reference state: refusal streak of B, lock flag, expected response of the previous cycle.
  int            starve;
  bit            locked;
  bit            pend_v, pend_b;
  logic [DW-1:0] pend_d;
  bit            acc_a, acc_b, obs_a_rdy, obs_b_rdy;

  dmem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_be(a_req_be), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_be(b_req_be), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .b_lock(b_lock),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with byte writes and one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      sram_w = sram[mem_addr];
      for (int k = 0; k < int'(BW); k++)
        if (mem_we[k]) sram_w[8*k +: 8] = mem_wdata[8*k +: 8];
      sram[mem_addr] <= sram_w;
      if (mem_we == '0) mem_rdata <= sram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [AW-1:0] addr, input logic [BW-1:0] be, input logic [DW-1:0] wd);
    logic [DW-1:0] w;
    w = ref_mem[addr];
    for (int k = 0; k < int'(BW); k++)
      if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
    ref_mem[addr] = w;
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge.
  task automatic tick(input string tag);
    bit            ea, eb, nv, nb;
    logic [BW-1:0] ewe;
    logic [DW-1:0] nd;
    #1;
    ea = a_req_valid && !locked && (!b_req_valid || starve < LIM);
    eb = b_req_valid && (locked || !a_req_valid || starve >= LIM);
    chk({tag, ".a_ready"}, 32'(a_req_ready), 32'(ea));
    chk({tag, ".b_ready"}, 32'(b_req_ready), 32'(eb));
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(ea || eb));
    obs_a_rdy = a_req_ready;
    obs_b_rdy = b_req_ready;
    if (ea || eb) begin
      if (eb) ewe = b_req_we ? b_req_be : '0;
      else    ewe = a_req_we ? a_req_be : '0;
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(eb ? b_req_addr : a_req_addr));
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(ewe));
      if (ewe != '0) chk({tag, ".mem_wdata"}, mem_wdata, eb ? b_req_wdata : a_req_wdata);
    end
    chk({tag, ".a_rsp_valid"}, 32'(a_rsp_valid), 32'(pend_v && !pend_b));
    chk({tag, ".b_rsp_valid"}, 32'(b_rsp_valid), 32'(pend_v && pend_b));
    if (pend_v) chk({tag, ".rsp_rdata"}, pend_b ? b_rsp_rdata : a_rsp_rdata, pend_d);
    @(posedge clk);
    nv = 1'b0; nb = 1'b0; nd = '0;
    if (ea) begin
      if (!a_req_we) begin nv = 1'b1; nd = ref_mem[a_req_addr]; end
      else ref_write(a_req_addr, a_req_be, a_req_wdata);
    end
    if (eb) begin
      if (!b_req_we) begin nv = 1'b1; nb = 1'b1; nd = ref_mem[b_req_addr]; end
      else ref_write(b_req_addr, b_req_be, b_req_wdata);
    end
    pend_v = nv; pend_b = nb; pend_d = nd;
    if (!locked && b_req_valid && !eb) starve = (starve < LIM) ? starve + 1 : LIM;
    else starve = 0;
`ifdef DMEM_ARB_LOCK_EN
    if (!locked && eb && b_lock) locked = 1'b1;
    else if (locked && !b_lock) locked = 1'b0;
`endif
    acc_a = ea;
    acc_b = eb;
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_be = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_be = '0; b_req_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    b_lock = 1'b0;
`endif
    starve = 0; locked = 1'b0; pend_v = 1'b0; pend_b = 1'b0; pend_d = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    sram[5] = 32'hAABBCCDD; ref_mem[5] = 32'hAABBCCDD;
    sram[7] = 32'h11223344; ref_mem[7] = 32'h11223344;

    // Reset state with both requesters pushing
    repeat (2) @(posedge clk);
    #1;
    a_req_valid = 1'b1; b_req_valid = 1'b1;
    #1;
    chk("rst.mem_en", 32'(mem_en), 32'd0);
    chk("rst.a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst.b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: reset lands mid-read, response must be dropped
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = '0;
    #1;
    chk("t1.a_ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t1.rst_mem_en", 32'(mem_en), 32'd0);
    chk("t1.rst_a_rsp", 32'(a_rsp_valid), 32'd0);
    chk("t1.rst_b_rsp", 32'(b_rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1.rst_a_rsp_edge", 32'(a_rsp_valid), 32'd0);
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend_v = 1'b0; starve = 0; locked = 1'b0;
    tick("t1.post0");
    tick("t1.post1");

    // 2: single read from A
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 14'd5;
    tick("t2.req");
    a_req_valid = 1'b0;
    #1;
    chk("t2.a_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("t2.a_rsp_rdata", a_rsp_rdata, 32'hAABBCCDD);
    chk("t2.b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    tick("t2.rsp");

    // 3: byte write from B
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 14'd7;
    b_req_be = 4'b0100; b_req_wdata = 32'h00BB0000;
    tick("t3.req");
    b_req_valid = 1'b0;
    tick("t3.none");
    chk("t3.mem7", sram[7], 32'h11BB3344);

    // 4: continuous contention, B gets every fifth slot
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 14'd3;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 14'd8;
    b_req_be = 4'hF; b_req_wdata = $urandom;
    for (int i = 0; i < 10; i++) begin
      tick("t4.cyc");
      chk("t4.b_grant", 32'(obs_b_rdy), 32'((i % 5) == 4));
      chk("t4.a_grant", 32'(obs_a_rdy), 32'((i % 5) != 4));
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    tick("t4.flush");

    // 5: alternating reads return in issue order
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 14'd1;
    tick("t5.a");
    a_req_valid = 1'b0;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 14'd2;
    tick("t5.b");
    b_req_valid = 1'b0;
    #1;
    chk("t5.b_rsp_valid", 32'(b_rsp_valid), 32'd1);
    chk("t5.b_rsp_rdata", b_rsp_rdata, sram[2]);
    chk("t5.a_rsp_off", 32'(a_rsp_valid), 32'd0);
    tick("t5.drain");

`ifdef DMEM_ARB_LOCK_EN
    // 6: locked B writes shut A out until one cycle after b_lock falls
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 14'd9;
    b_req_be = 4'hF; b_req_wdata = $urandom; b_lock = 1'b1;
    tick("t6.enter");
    chk("t6.b_first", 32'(obs_b_rdy), 32'd1);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 14'd4;
    for (int i = 0; i < 2; i++) begin
      tick("t6.locked");
      chk("t6.a_blocked", 32'(obs_a_rdy), 32'd0);
    end
    b_lock = 1'b0; b_req_valid = 1'b0;
    tick("t6.fall");
    chk("t6.a_fall", 32'(obs_a_rdy), 32'd0);
    tick("t6.after");
    chk("t6.a_after", 32'(obs_a_rdy), 32'd1);
    a_req_valid = 1'b0;
    tick("t6.flush");
`endif

    // Randomized traffic: requests held until accepted
    for (int n = 0; n < 400; n++) begin
      if (!a_req_valid && ($urandom_range(0, 2) != 0)) begin
        a_req_valid = 1'b1;
        a_req_we    = 1'($urandom_range(0, 1));
        a_req_addr  = AW'($urandom_range(0, 15));
        a_req_be    = BW'($urandom);
        a_req_wdata = $urandom;
      end
      if (!b_req_valid && ($urandom_range(0, 2) != 0)) begin
        b_req_valid = 1'b1;
        b_req_we    = 1'($urandom_range(0, 1));
        b_req_addr  = AW'($urandom_range(0, 15));
        b_req_be    = BW'($urandom);
        b_req_wdata = $urandom;
      end
`ifdef DMEM_ARB_LOCK_EN
      b_lock = ($urandom_range(0, 4) == 0);
`endif
      tick("rnd");
      if (acc_a) a_req_valid = 1'b0;
      if (acc_b) b_req_valid = 1'b0;
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    b_lock = 1'b0;
`endif
    tick("end.flush0");
    tick("end.flush1");
    for (int i = 0; i < 16; i++) chk("end.mem", sram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
